// File: rtl/disp_mux_pkg.sv
// rtl/disp_mux_pkg.sv - shared helpers for the multiplexed display scanner
//
// Purpose : index-width helper and anode drive level constants shared by
//           disp_mux_n and tick_gen.
// Ports   : none (package).

package disp_mux_pkg;

  // Anode "on" level for each polarity; "off" is always the complement.
  localparam logic AN_ON_ACTIVE_HIGH = 1'b1;
  localparam logic AN_ON_ACTIVE_LOW  = 1'b0;

  // clog2 with a floor of 1 so a single-entry index still has a real bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/disp_mux_n_tick_gen.sv
// rtl/disp_mux_n_tick_gen.sv - prescale counter producing the slot-advance strobe
//
// Purpose : counts 0..PRESCALE-1 while enabled; tick is high (combinationally)
//           in the cycle the count equals PRESCALE-1, which is the cycle the
//           scanner advances its slot index.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous active-low reset (count -> 0)
//           enable - count enable; count holds and tick is 0 when low
//           tick   - slot-advance strobe

module tick_gen
  import disp_mux_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = idx_width(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = enable && (r_cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/disp_mux_n.sv
// rtl/disp_mux_n.sv - N-digit multiplexed display scanner with PWM and LZ blanking
//
// Purpose : scans NUM_DIGITS digits one slot at a time, presenting the slot's
//           value on muxd and a one-hot anode drive on adrive, dimmed by a
//           free-running PWM and masked by blank / leading-zero suppression.
// Ports   : clk         - rising-edge clock
//           reset       - asynchronous active-low reset
//           enable      - scan enable; counters and muxd hold when low
//           digits      - packed digit values, digit k at [k*DIGIT_W +: DIGIT_W]
//           blank       - per-digit blank mask
//           brightness  - PWM duty (all ones = always on)
//           lz_suppress - suppress leading zero digits (never digit 0)
//           muxd        - registered value of the current digit
//           adrive      - registered one-hot anode drive (polarity per ACTIVE_LOW_AN)
//           digit_idx   - current slot index
//           frame_tick  - one-cycle pulse after the index wraps to 0

module disp_mux_n
  import disp_mux_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int DIGIT_W       = 4,
  parameter int PRESCALE      = 1,
  parameter int DUTY_W        = 4,
  parameter int ACTIVE_LOW_AN = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]    digits,
  input  logic [NUM_DIGITS-1:0]            blank,
  input  logic [DUTY_W-1:0]                brightness,
  input  logic                             lz_suppress,
  output logic [DIGIT_W-1:0]               muxd,
  output logic [NUM_DIGITS-1:0]            adrive,
  output logic [idx_width(NUM_DIGITS)-1:0] digit_idx,
  output logic                             frame_tick
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic AN_ON  = (ACTIVE_LOW_AN != 0) ? AN_ON_ACTIVE_LOW : AN_ON_ACTIVE_HIGH;
  localparam logic AN_OFF = ~AN_ON;

  logic [IDX_W-1:0]      r_idx;
  logic [DUTY_W-1:0]     r_pwm;
  logic [DIGIT_W-1:0]    r_muxd;
  logic [NUM_DIGITS-1:0] r_adrive;
  logic                  r_frame;

  logic                  w_tick;
  logic                  w_pwm_on;
  logic                  w_drive;
  logic                  w_seen_nz;
  logic                  w_blank_cur;
  logic                  w_supp_cur;
  logic [DIGIT_W-1:0]    w_digit;
  logic [NUM_DIGITS-1:0] w_supp;
  logic [NUM_DIGITS-1:0] w_adrive_nxt;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (w_tick)
  );

  // All-ones duty means fully on; otherwise the PWM would miss one cycle in 2^DUTY_W.
  assign w_pwm_on = (r_pwm < brightness) || (&brightness);

  // Walk from the most significant digit down: a digit is a leading zero
  // until some digit at or above it is non-zero. Digit 0 is never included.
  always_comb begin
    w_supp    = '0;
    w_seen_nz = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_seen_nz = w_seen_nz | (|digits[k*DIGIT_W +: DIGIT_W]);
      w_supp[k] = lz_suppress && !w_seen_nz;
    end
  end

  // Select everything belonging to the current slot with an explicit compare
  // so non-power-of-two digit counts never index out of range.
  always_comb begin
    w_digit     = '0;
    w_blank_cur = 1'b0;
    w_supp_cur  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_digit     = digits[k*DIGIT_W +: DIGIT_W];
        w_blank_cur = blank[k];
        w_supp_cur  = w_supp[k];
      end
    end
  end

  assign w_drive = enable && w_pwm_on && !w_blank_cur && !w_supp_cur;

  always_comb begin
    w_adrive_nxt = {NUM_DIGITS{AN_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_drive && (r_idx == IDX_W'(k))) begin
        w_adrive_nxt[k] = AN_ON;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx    <= '0;
      r_pwm    <= '0;
      r_muxd   <= '0;
      r_adrive <= {NUM_DIGITS{AN_OFF}};
      r_frame  <= 1'b0;
    end else begin
      // Anode drive clears while disabled; enable is folded into w_drive.
      r_adrive <= w_adrive_nxt;
      // w_tick is already gated by enable, so the pulse is 0 while disabled.
      r_frame  <= w_tick && (r_idx == LAST_IDX);
      if (enable) begin
        r_pwm  <= r_pwm + DUTY_W'(1);
        r_muxd <= w_digit;
        if (w_tick) begin
          r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
        end
      end
    end
  end

  assign muxd       = r_muxd;
  assign adrive     = r_adrive;
  assign digit_idx  = r_idx;
  assign frame_tick = r_frame;

endmodule

// File: doc/disp_mux_n.md
DISP_MUX_N -- requirements
Module: disp_mux_n

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, meaning digits scanned (legal 1..16).
REQ-002 The block SHALL have parameter DIGIT_W, default 4, meaning bits per digit value.
REQ-003 The block SHALL have parameter PRESCALE, default 1, meaning clk cycles per digit slot (legal >=1).
REQ-004 The block SHALL have parameter DUTY_W, default 4, meaning brightness width.
REQ-005 The block SHALL have parameter ACTIVE_LOW_AN, default 0, meaning anode polarity (1 = active-low adrive).
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single clock (rising edge).
REQ-007 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-low reset.
REQ-008 The block SHALL have port enable, input, 1 bit, meaning scan enable.
REQ-009 The block SHALL have port digits, input, NUM_DIGITS*DIGIT_W bits, meaning packed digit values; digit k = bits [k*DIGIT_W +: DIGIT_W].
REQ-010 The block SHALL have port blank, input, NUM_DIGITS bits, meaning per-digit blank mask.
REQ-011 The block SHALL have port brightness, input, DUTY_W bits, meaning PWM duty.
REQ-012 The block SHALL have port lz_suppress, input, 1 bit, meaning leading-zero suppression enable.
REQ-013 The block SHALL have port muxd, output, DIGIT_W bits, meaning the selected digit value.
REQ-014 The block SHALL have port adrive, output, NUM_DIGITS bits, meaning one-hot anode drive.
REQ-015 The block SHALL have port digit_idx, output, max(1,clog2(NUM_DIGITS)) bits, meaning the current slot index.
REQ-016 The block SHALL have port frame_tick, output, 1 bit, meaning a one-cycle pulse on index wrap.

Function
REQ-017 The prescale counter SHALL count 0..PRESCALE-1 and issue a slot advance in the cycle it equals PRESCALE-1.
REQ-018 On slot advance, idx SHALL increment, wrapping NUM_DIGITS-1 -> 0; frame_tick SHALL be 1 in the cycle after the wrap edge only.
REQ-019 With NUM_DIGITS=1, idx SHALL stay 0 and frame_tick SHALL pulse on every slot advance.
REQ-020 A DUTY_W-bit PWM counter SHALL free-run (+1 per enabled cycle, wrapping); pwm_on = (pwm_cnt < brightness) or (brightness == all ones).
REQ-021 Digit k SHALL be suppressed when lz_suppress=1, k>0, and digits k..NUM_DIGITS-1 are all zero; digit 0 SHALL never be LZ-suppressed.
REQ-022 muxd SHALL be registered and equal to digit[idx] one cycle after idx/inputs, including for blanked or suppressed digits.
REQ-023 adrive SHALL be registered: bit idx active iff enable & pwm_on & !blank[idx] & !suppressed(idx); all other bits inactive.
REQ-024 "Active" SHALL mean 1 when ACTIVE_LOW_AN=0 and 0 when ACTIVE_LOW_AN=1.
REQ-025 With enable=0, all counters and muxd SHALL hold, adrive SHALL go all-inactive next cycle, and frame_tick SHALL be 0.
REQ-026 Changes to blank/brightness/digits mid-slot SHALL take effect on the next clock edge; no slot restart.

Reset
REQ-027 On reset=0 (asynchronous), idx, prescale count, pwm_cnt, muxd and frame_tick SHALL be 0, and adrive SHALL be all-inactive.
REQ-028 Scanning SHALL restart at slot 0, count 0, on the first enabled edge after reset deasserts.

Structure
REQ-029 The shared package disp_mux_pkg SHALL hold the index-width function (clog2 with min 1) and the anode active/inactive level constants.
REQ-030 Prescale and slot advance SHALL be one sub-module, tick_gen (params PRESCALE; ports clk, reset, enable, tick); the remainder is flat.

Verification (NUM_DIGITS=4, DIGIT_W=4, PRESCALE=4, DUTY_W=4 unless stated)
REQ-031 Scan: digits=16'h3210, blank=0, brightness=F, enable=1 -> adrive 0001/0010/0100/1000 for 4 cycles each with muxd 0/1/2/3; frame_tick once per 16 cycles.
REQ-032 Blank: blank=4'b1100 -> adrive=0000 during slots 2 and 3; muxd still 2, 3.
REQ-033 LZ: lz_suppress=1, digits=16'h0050 -> only slots 0 and 1 drive; with digits=16'h0000 -> only slot 0 drives.
REQ-034 PWM: PRESCALE=16, brightness=4 -> adrive active 4 of 16 cycles per slot; brightness=0 -> adrive never active.
REQ-035 Reset mid-scan: assert reset at idx=2, between clock edges -> adrive=0000 and idx=0 immediately; ACTIVE_LOW_AN=1 -> adrive=1111, then 1110 in slot 0.
REQ-036 Enable: drop enable at idx=1 for 10 cycles -> adrive all-inactive, idx=1 held; resume in slot 1 at the held count.
